icache_fill_engine: RTL and testbench

- Sits directly downstream of the instruction cache, on its L1 request/return path.
- Accepts one line-fill request at a time and issues a line-aligned burst read on a simple address/read-data memory bus. Returns the words to the cache in ascending order, one per cycle, with no back-pressure on the cache side.
- Also queues externally snooped write addresses and presents them to the cache as invalidations, with a handshake.

---
 rtl/icache_fill_engine.sv | 153 +++++++++++++++
 tb/tb_icache_fill_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_engine.sv
// Purpose: line-fill burst engine between the icache and memory, plus a snoop invalidation queue.
// Latency: request accept to mem_ar_valid 1 cycle; memory beat to rsp_data 1 cycle.
// Backpressure: none toward the cache data path; snoops stall on a full queue; fills wait for the queue to drain.
module icache_fill_engine #(
  parameter int LINE_W    = 4,
  parameter int INV_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_size,
  output logic        req_ack,
  output logic        mem_ar_valid,
  input  logic        mem_ar_ready,
  output logic [31:0] mem_ar_addr,
  output logic [4:0]  mem_ar_len,
  input  logic        mem_r_valid,
  input  logic [31:0] mem_r_data,
  input  logic        mem_r_last,
  output logic        mem_r_ready,
  output logic        rsp_data_valid,
  output logic [31:0] rsp_data,
  input  logic        snoop_valid,
  input  logic [29:0] snoop_addr,
  output logic        snoop_ready,
  output logic        inv_valid,
  output logic [29:0] inv_addr,
  input  logic        inv_ack,
  output logic        protocol_error
);

  // Word-offset bits within a line; the beat counter needs at least one bit.
  localparam int          OFF_W     = $clog2(LINE_W);
  localparam int          CNT_W     = (OFF_W < 1) ? 1 : OFF_W;
  localparam int          IDX_W     = $clog2(INV_DEPTH);
  localparam logic [31:0] LINE_MASK = ~((32'(LINE_W) << 2) - 32'd1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat;
  logic             beat_is_last;

  logic [29:0]      inv_mem [INV_DEPTH];
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic             q_empty;
  logic             q_full;
  logic             push;
  logic             pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign q_empty     = (wr_ptr == rd_ptr);
  assign q_full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign snoop_ready = ~q_full;
  assign push        = snoop_valid & ~q_full;
  assign pop         = inv_valid & inv_ack;

  // mem_r_ready is exactly "state is DATA", so derive the beat strobe from state directly.
  assign beat         = mem_r_valid & (state == DATA);
  assign beat_is_last = ({{(5-CNT_W){1'b0}}, beat_cnt} == mem_ar_len);

  // Next-state and handshake outputs; pending invalidations take priority over new fills.
  always_comb begin
    state_nxt    = state;
    req_ack      = 1'b0;
    mem_ar_valid = 1'b0;
    mem_r_ready  = 1'b0;
    inv_valid    = 1'b0;
    inv_addr     = '0;
    unique case (state)
      IDLE: begin
        if (!q_empty) begin
          inv_valid = 1'b1;
          inv_addr  = inv_mem[rd_ptr[IDX_W-1:0]];
        end else if (req_valid) begin
          req_ack   = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        mem_ar_valid = 1'b1;
        if (mem_ar_ready) state_nxt = DATA;
      end
      DATA: begin
        mem_r_ready = 1'b1;
        if (mem_r_valid && beat_is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the line-aligned burst address and length when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ar_addr <= '0;
      mem_ar_len  <= '0;
    end else if (req_ack) begin
      mem_ar_addr <= req_addr & LINE_MASK;
      mem_ar_len  <= req_size;
    end
  end

  // Beat counter: cleared while the address phase runs, wraps to zero on the final beat.
  always_ff @(posedge clk) begin
    if (rst || state == ADDR) beat_cnt <= '0;
    else if (beat)            beat_cnt <= beat_is_last ? '0 : beat_cnt + CNT_W'(1);
  end

  // Forward each accepted beat to the cache one cycle later; rsp_data holds between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_valid <= 1'b0;
      rsp_data       <= '0;
    end else begin
      rsp_data_valid <= beat;
      if (beat) rsp_data <= mem_r_data;
    end
  end

  // Sticky flag when memory's last marker disagrees with our own beat count.
  always_ff @(posedge clk) begin
    if (rst)                                   protocol_error <= 1'b0;
    else if (beat && (mem_r_last != beat_is_last)) protocol_error <= 1'b1;
  end

  // Invalidation queue pointers; push and pop may both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Invalidation queue storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) inv_mem[wr_ptr[IDX_W-1:0]] <= snoop_addr;
  end

endmodule

// File: tb/tb_icache_fill_engine.sv
// Directed bench for icache_fill_engine (LINE_W=4, INV_DEPTH=4).
// Inputs driven 1 time unit after the rising edge, outputs checked 1 unit later.
// Each scenario task carries its own inline comparisons.
module tb_icache_fill_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [4:0]  req_size;
  logic        req_ack;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic [4:0]  mem_ar_len;
  logic        mem_r_valid;
  logic [31:0] mem_r_data;
  logic        mem_r_last;
  logic        mem_r_ready;
  logic        rsp_data_valid;
  logic [31:0] rsp_data;
  logic        snoop_valid;
  logic [29:0] snoop_addr;
  logic        snoop_ready;
  logic        inv_valid;
  logic [29:0] inv_addr;
  logic        inv_ack;
  logic        protocol_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icache_fill_engine #(.LINE_W(4), .INV_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size), .req_ack(req_ack),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
    .mem_ar_addr(mem_ar_addr), .mem_ar_len(mem_ar_len),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_last(mem_r_last),
    .mem_r_ready(mem_r_ready),
    .rsp_data_valid(rsp_data_valid), .rsp_data(rsp_data),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_ready(snoop_ready),
    .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ack(inv_ack),
    .protocol_error(protocol_error)
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run a 4-beat fill already in ADDR to completion without checking it.
  task automatic drain_fill();
    mem_ar_ready = 1'b1;
    cyc();
    mem_ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_r_valid = 1'b1; mem_r_data = 32'hEE + i; mem_r_last = (i == 3);
      cyc();
    end
    mem_r_valid = 1'b0; mem_r_last = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_addr = 0; req_size = 5'd3;
    mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = 0; mem_r_last = 0;
    snoop_valid = 0; snoop_addr = 0; inv_ack = 0;
    cyc(); cyc();
    #1;
    tests++; if (req_ack !== 1'b0) begin fails++; $display("FAIL reset_req_ack got %b exp 0", req_ack); end
    tests++; if (mem_ar_valid !== 1'b0) begin fails++; $display("FAIL reset_ar_valid got %b exp 0", mem_ar_valid); end
    tests++; if (mem_r_ready !== 1'b0) begin fails++; $display("FAIL reset_r_ready got %b exp 0", mem_r_ready); end
    tests++; if (rsp_data_valid !== 1'b0 || rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp got %b/%h exp 0/0", rsp_data_valid, rsp_data); end
    tests++; if (inv_valid !== 1'b0 || inv_addr !== 30'h0) begin fails++; $display("FAIL reset_inv got %b/%h exp 0/0", inv_valid, inv_addr); end
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL reset_perr got %b exp 0", protocol_error); end
    tests++; if (snoop_ready !== 1'b1) begin fails++; $display("FAIL reset_snoop_ready got %b exp 1", snoop_ready); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic_fill();
    req_valid = 1'b1; req_addr = 32'h0000_1238; req_size = 5'd3; mem_ar_ready = 1'b1;
    #1;
    tests++; if (req_ack !== 1'b1) begin fails++; $display("FAIL basic_req_ack got %b exp 1", req_ack); end
    cyc();
    req_valid = 1'b0;
    #1;
    tests++; if (mem_ar_valid !== 1'b1) begin fails++; $display("FAIL basic_ar_valid got %b exp 1", mem_ar_valid); end
    tests++; if (mem_ar_addr !== 32'h0000_1230) begin fails++; $display("FAIL basic_ar_addr got %h exp 00001230", mem_ar_addr); end
    tests++; if (mem_ar_len !== 5'd3) begin fails++; $display("FAIL basic_ar_len got %0d exp 3", mem_ar_len); end
    cyc();
    mem_ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_r_valid = 1'b1; mem_r_data = 32'hA0 + i; mem_r_last = (i == 3);
      #1;
      tests++; if (mem_r_ready !== 1'b1) begin fails++; $display("FAIL basic_r_ready beat %0d got %b exp 1", i, mem_r_ready); end
      cyc();
      mem_r_valid = 1'b0; mem_r_last = 1'b0;
      #1;
      tests++; if (rsp_data_valid !== 1'b1 || rsp_data !== 32'hA0 + i) begin fails++; $display("FAIL basic_rsp beat %0d got %b/%h exp 1/%h", i, rsp_data_valid, rsp_data, 32'hA0 + i); end
    end
    tests++; if (mem_r_ready !== 1'b0 || mem_ar_valid !== 1'b0) begin fails++; $display("FAIL basic_idle got r_ready %b ar_valid %b exp 0 0", mem_r_ready, mem_ar_valid); end
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL basic_perr got %b exp 0", protocol_error); end
    cyc();
    tests++; if (rsp_data_valid !== 1'b0) begin fails++; $display("FAIL basic_rsp_end got %b exp 0", rsp_data_valid); end
  endtask

  task automatic test_mem_stall();
    logic [5:0] pat;
    int b;
    pat = 6'b110011;  // bit k = beat presented in DATA cycle k (LSB first)
    b = 0;
    req_valid = 1'b1; req_addr = 32'h0000_2004; req_size = 5'd3;
    #1;
    tests++; if (req_ack !== 1'b1) begin fails++; $display("FAIL stall_req_ack got %b exp 1", req_ack); end
    cyc();
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mem_ar_ready = (k == 4);
      #1;
      tests++; if (mem_ar_valid !== 1'b1 || mem_ar_addr !== 32'h0000_2000) begin fails++; $display("FAIL stall_ar cycle %0d got %b/%h exp 1/00002000", k, mem_ar_valid, mem_ar_addr); end
      cyc();
    end
    mem_ar_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_r_valid = pat[k]; mem_r_data = 32'hB0 + b; mem_r_last = pat[k] && (b == 3);
      cyc();
      mem_r_valid = 1'b0; mem_r_last = 1'b0;
      #1;
      tests++; if (rsp_data_valid !== pat[k]) begin fails++; $display("FAIL stall_rsp_valid cycle %0d got %b exp %b", k, rsp_data_valid, pat[k]); end
      if (pat[k]) begin
        tests++; if (rsp_data !== 32'hB0 + b) begin fails++; $display("FAIL stall_rsp_data beat %0d got %h exp %h", b, rsp_data, 32'hB0 + b); end
        b++;
      end
    end
    tests++; if (mem_r_ready !== 1'b0) begin fails++; $display("FAIL stall_idle got r_ready %b exp 0", mem_r_ready); end
    cyc();
  endtask

  task automatic test_snoop_priority();
    snoop_valid = 1'b1; snoop_addr = 30'h0400_0010;
    cyc();
    snoop_valid = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_3000; req_size = 5'd3;
    for (int k = 0; k < 2; k++) begin
      inv_ack = (k == 1);
      #1;
      tests++; if (inv_valid !== 1'b1 || inv_addr !== 30'h0400_0010) begin fails++; $display("FAIL prio_inv cycle %0d got %b/%h exp 1/04000010", k, inv_valid, inv_addr); end
      tests++; if (req_ack !== 1'b0) begin fails++; $display("FAIL prio_req_blocked cycle %0d got %b exp 0", k, req_ack); end
      cyc();
    end
    inv_ack = 1'b0;
    #1;
    tests++; if (inv_valid !== 1'b0) begin fails++; $display("FAIL prio_inv_popped got %b exp 0", inv_valid); end
    tests++; if (req_ack !== 1'b1) begin fails++; $display("FAIL prio_req_ack got %b exp 1", req_ack); end
    cyc();
    req_valid = 1'b0;
    drain_fill();
  endtask

  task automatic test_queue_full();
    for (int i = 1; i <= 4; i++) begin
      snoop_valid = 1'b1; snoop_addr = 30'h10 + i;
      #1;
      tests++; if (snoop_ready !== 1'b1) begin fails++; $display("FAIL full_push_ready %0d got %b exp 1", i, snoop_ready); end
      cyc();
    end
    snoop_addr = 30'h15;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (snoop_ready !== 1'b0) begin fails++; $display("FAIL full_ready cycle %0d got %b exp 0", k, snoop_ready); end
      tests++; if (inv_valid !== 1'b1 || inv_addr !== 30'h11) begin fails++; $display("FAIL full_head cycle %0d got %b/%h exp 1/11", k, inv_valid, inv_addr); end
      cyc();
    end
    // First ack frees a slot; the second ack pops while the held snoop pushes.
    inv_ack = 1'b1;
    #1;
    tests++; if (inv_addr !== 30'h11 || snoop_ready !== 1'b0) begin fails++; $display("FAIL full_pop1 got %h/%b exp 11/0", inv_addr, snoop_ready); end
    cyc();
    #1;
    tests++; if (inv_addr !== 30'h12 || snoop_ready !== 1'b1) begin fails++; $display("FAIL full_pop_push got %h/%b exp 12/1", inv_addr, snoop_ready); end
    cyc();
    snoop_valid = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      #1;
      tests++; if (inv_valid !== 1'b1 || inv_addr !== 30'h10 + i) begin fails++; $display("FAIL full_order got %b/%h exp 1/%h", inv_valid, inv_addr, 30'h10 + i); end
      tests++; if (snoop_ready !== 1'b1) begin fails++; $display("FAIL full_drain_ready got %b exp 1", snoop_ready); end
      cyc();
    end
    inv_ack = 1'b0;
    #1;
    tests++; if (inv_valid !== 1'b0) begin fails++; $display("FAIL full_empty got %b exp 0", inv_valid); end
  endtask

  task automatic test_bad_last();
    req_valid = 1'b1; req_addr = 32'h0000_4010; req_size = 5'd3; mem_ar_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    #1;
    tests++; if (mem_ar_addr !== 32'h0000_4010) begin fails++; $display("FAIL bad_ar_addr got %h exp 00004010", mem_ar_addr); end
    cyc();
    mem_ar_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_r_valid = 1'b1; mem_r_data = 32'hC0 + i; mem_r_last = (i == 1);
      cyc();
      mem_r_valid = 1'b0; mem_r_last = 1'b0;
      #1;
      tests++; if (rsp_data_valid !== 1'b1 || rsp_data !== 32'hC0 + i) begin fails++; $display("FAIL bad_rsp beat %0d got %b/%h exp 1/%h", i, rsp_data_valid, rsp_data, 32'hC0 + i); end
      tests++; if (protocol_error !== (i >= 1)) begin fails++; $display("FAIL bad_perr beat %0d got %b exp %b", i, protocol_error, (i >= 1)); end
    end
    tests++; if (mem_r_ready !== 1'b0) begin fails++; $display("FAIL bad_idle got r_ready %b exp 0", mem_r_ready); end
    cyc(); cyc();
    tests++; if (protocol_error !== 1'b1) begin fails++; $display("FAIL bad_sticky got %b exp 1", protocol_error); end
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 1'b1; req_addr = 32'h0000_5000; req_size = 5'd3; mem_ar_ready = 1'b1;
    cyc();
    req_valid = 1'b0;
    cyc();
    mem_ar_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_r_valid = 1'b1; mem_r_data = 32'hD0 + i; mem_r_last = 1'b0;
      snoop_valid = (i == 1); snoop_addr = 30'h2AA;
      cyc();
    end
    mem_r_valid = 1'b0; snoop_valid = 1'b0;
    rst = 1'b1;
    cyc();
    #1;
    tests++; if (req_ack !== 1'b0 || mem_ar_valid !== 1'b0 || mem_r_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_fsm got ack %b ar %b r %b exp 0 0 0", req_ack, mem_ar_valid, mem_r_ready); end
    tests++; if (rsp_data_valid !== 1'b0 || rsp_data !== 32'h0) begin fails++; $display("FAIL mid_rst_rsp got %b/%h exp 0/0", rsp_data_valid, rsp_data); end
    tests++; if (inv_valid !== 1'b0 || inv_addr !== 30'h0) begin fails++; $display("FAIL mid_rst_inv got %b/%h exp 0/0", inv_valid, inv_addr); end
    tests++; if (protocol_error !== 1'b0 || snoop_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_flags got perr %b snoop_ready %b exp 0 1", protocol_error, snoop_ready); end
    rst = 1'b0;
    cyc();
    #1;
    tests++; if (inv_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_queue_empty got %b exp 0", inv_valid); end
    cyc();
    test_basic_fill();
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_mem_stall();
    test_snoop_priority();
    test_queue_full();
    test_bad_last();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
